ft601_mcfifo_tx_arbiter: RTL and testbench
==========================================

// Module: ft601_mcfifo_tx_arbiter
// PURPOSE
// - Shares the FT601 transmit bus among NUM_CH packetizing write buffers (read side, FT601 clock domain).
// - Picks one requesting channel round-robin, runs one complete packet burst from that buffer to the FT601 bus driver, then rearbitrates.
// - Guarantees contiguous bursts: no channel switch inside a packet.
// PARAMETERS
// - NUM_CH       4   number of buffer channels (1, 2 or 4)
// - GAP_CYCLES   2   idle cycles between bursts for bus turnaround (0..15)
// PORTS
// - rd_clk            in   1          FT601 clock; all logic on negedge rd_clk (matches the buffer read side)
// - rd_reset_n        in   1          asynchronous, active-low reset
// - ch_enable         in   NUM_CH     config: channel may be granted; quasi-static
// - ch_space          in   NUM_CH     FT601 channel has room for a full packet (from driver status)
// - ch_xfer_req       in   NUM_CH     buffer has a packet pending (already low once its transfer completes)
// - ch_xfer_done      in   NUM_CH     buffer byte count == packet size
// - ch_xfer_almost_done in NUM_CH     one word left in packet
// - ch_rd_data        in   32*NUM_CH  FWFT data, channel i at [32i+:32]
// - ch_rd_be          in   4*NUM_CH   FWFT byte enables
// - ch_rd_valid       in   NUM_CH     FWFT data valid
// - ch_rd_en          out  NUM_CH     pop strobe to buffer
// - phy_req           out  1          request burst on phy_ch
// - phy_ch            out  2          granted channel index
// - phy_gnt           in   1          driver accepted request (1-cycle pulse)
// - phy_data_en       in   1          driver consumes one word this cycle
// - phy_data          out  32         word to driver
// - phy_be            out  4          byte enables to driver
// - phy_last          out  1          current word is last of packet
// - busy              out  1          state != IDLE
// - underrun_err      out  1          sticky: phy_data_en while granted ch_rd_valid low
// BEHAVIOUR
// - Reset: state IDLE, rr pointer 0, all outputs 0.
// - eligible[i] = ch_xfer_req[i] & ch_enable[i] & ch_space[i].
// - IDLE: if any eligible -> ARB.
// - ARB (1 cycle): grant = first eligible searching from rr_ptr upward, wrapping; register gnt_idx; -> REQ. If eligible vanished -> IDLE.
// - REQ: phy_req=1, phy_ch=gnt_idx; on phy_gnt -> BURST, rr_ptr <= gnt_idx+1 mod NUM_CH.
// - BURST: ch_rd_en[gnt_idx] = phy_data_en (combinational, same cycle); phy_data/phy_be = granted FWFT outputs, unregistered; phy_last = ch_xfer_almost_done[gnt_idx]. On phy_data_en & phy_last -> GAP.
// - Underrun: phy_data_en with ch_rd_valid low sets underrun_err; rd_en still issued; cleared only by reset.
// - GAP: hold GAP_CYCLES cycles (0 -> single pass-through cycle), then IDLE. Masks the stale ch_xfer_req of the finished channel during handshake fallback.
// - Only one ch_rd_en bit ever high; none high outside BURST.
// - Zero-length packets never reach the arbiter (buffer gates req with done).
// - ch_enable dropping in REQ/BURST: ignored until burst ends (no mid-packet abort).
// - ch_xfer_done[gnt_idx] high on BURST entry: treated as protocol error, set underrun_err, -> GAP.
// - Reset mid-burst: immediate return to IDLE, rd_en low; buffers reset together by system.
// - rr_ptr width clog2(NUM_CH), wrap explicit for non-power-of-2 safety.
// CONFIGURATION
// - FT601_ARB_STATS_EN defined: per-channel 32-bit pkt_count and word_count outputs (stat_pkts[32*NUM_CH], stat_words[32*NUM_CH]), incremented on last word / each phy_data_en; wrap at 2^32; stat_clr input zeroes all counters synchronously.
// - Undefined: stat ports and counters absent; core behaviour identical.
// STRUCTURE
// - Package ft601_mcfifo_pkg: arb_state_e (IDLE, ARB, REQ, BURST, GAP), BYTES_PER_WORD=4, MAX_CH=4, CH_IDX_W=2.
// - Sub-module rr_arbiter (NUM_CH): combinational round-robin pick from eligible and rr_ptr; returns idx and any.
// TESTING
// - Ch0 only, 16-byte packet: req ch0 -> phy_req, phy_ch=0; after gnt, 4 phy_data_en -> 4 rd_en, phy_last on 4th, GAP 2 cycles, IDLE.
// - Ch0..3 all requesting continuously: grant order 0,1,2,3,0; no back-to-back same channel while others eligible.
// - ch_space[1]=0 with ch1,ch2 requesting: ch2 granted; ch1 granted once space returns.
// - phy_data_en stalls (1 of 3 cycles) in 4096-byte burst: exactly 1024 rd_en, data order preserved, no channel switch.
// - ch_rd_valid low during phy_data_en: underrun_err=1, held until rd_reset_n.
// - rd_reset_n low mid-BURST: all outputs 0 within same cycle; FT601_ARB_STATS_EN build: 3 packets of 8 bytes ch2 -> stat_pkts[2]=3, stat_words[2]=6.

Source files
------------

// File: rtl/ft601_mcfifo_pkg.sv
// Shared types and constants for the FT601 multi-channel FIFO transmit path.
package ft601_mcfifo_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    REQ   = 3'd2,
    BURST = 3'd3,
    GAP   = 3'd4
  } arb_state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int MAX_CH         = 4;
  localparam int CH_IDX_W       = 2;

  // Pointer width that stays at least one bit wide for a single-channel build.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ft601_mcfifo_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: lowest eligible channel at or above rr_ptr,
// otherwise the lowest eligible channel overall (wrap-around).
module rr_arbiter
  import ft601_mcfifo_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = ptr_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [PTR_W-1:0]  idx,
  output logic              any
);

  logic [NUM_CH-1:0] below;
  logic [NUM_CH-1:0] upper;
  logic [NUM_CH-1:0] cand;

  // Split the request vector at the pointer and priority-encode the winning half.
  always_comb begin
    idx   = '0;
    below = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      below[i] = (i < int'(rr_ptr));
    end
    upper = eligible & ~below;
    cand  = (|upper) ? upper : eligible;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = cand[i] ? PTR_W'(i) : idx;
    end
    any = |eligible;
  end

endmodule

// File: rtl/ft601_mcfifo_tx_arbiter.sv
// Round-robin arbiter handing whole packet bursts from NUM_CH buffers to the FT601 driver.
// Optional build macro FT601_ARB_STATS_EN adds per-channel packet/word counters.
module ft601_mcfifo_tx_arbiter
  import ft601_mcfifo_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     rd_clk,
  input  logic                     rd_reset_n,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        ch_space,
  input  logic [NUM_CH-1:0]        ch_xfer_req,
  input  logic [NUM_CH-1:0]        ch_xfer_done,
  input  logic [NUM_CH-1:0]        ch_xfer_almost_done,
  input  logic [WORD_W*NUM_CH-1:0] ch_rd_data,
  input  logic [4*NUM_CH-1:0]      ch_rd_be,
  input  logic [NUM_CH-1:0]        ch_rd_valid,
  output logic [NUM_CH-1:0]        ch_rd_en,
  output logic                     phy_req,
  output logic [CH_IDX_W-1:0]      phy_ch,
  input  logic                     phy_gnt,
  input  logic                     phy_data_en,
  output logic [WORD_W-1:0]        phy_data,
  output logic [3:0]               phy_be,
  output logic                     phy_last,
  output logic                     busy,
  output logic                     underrun_err
`ifdef FT601_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [32*NUM_CH-1:0]     stat_pkts,
  output logic [32*NUM_CH-1:0]     stat_words
`endif
);

  localparam int                PTR_W    = ptr_width(NUM_CH);
  localparam logic [3:0]        GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic [PTR_W-1:0]  LAST_CH  = PTR_W'(NUM_CH - 1);

  arb_state_e          state;
  arb_state_e          state_nxt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_any;
  logic [3:0]          gap_cnt;
  logic                burst_first;
  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   gnt_onehot;
  logic [WORD_W-1:0]   sel_data;
  logic [3:0]          sel_be;
  logic                sel_valid;
  logic                sel_almost;
  logic                sel_done;
  logic                burst_ok;
  logic                proto_err;
  logic                word_take;
  logic                last_take;

  assign eligible = ch_xfer_req & ch_enable & ch_space;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_arbiter (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .idx      (arb_idx),
    .any      (arb_any)
  );

  // Route the granted channel's FWFT outputs and status.
  always_comb begin
    gnt_onehot = '0;
    sel_data   = '0;
    sel_be     = 4'd0;
    sel_valid  = 1'b0;
    sel_almost = 1'b0;
    sel_done   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_onehot[i] = (gnt_idx == PTR_W'(i));
      sel_data      = gnt_onehot[i] ? ch_rd_data[WORD_W*i +: WORD_W] : sel_data;
      sel_be        = gnt_onehot[i] ? ch_rd_be[4*i +: 4] : sel_be;
      sel_valid     = gnt_onehot[i] ? ch_rd_valid[i] : sel_valid;
      sel_almost    = gnt_onehot[i] ? ch_xfer_almost_done[i] : sel_almost;
      sel_done      = gnt_onehot[i] ? ch_xfer_done[i] : sel_done;
    end
  end

  // A buffer already reporting done on the first burst cycle has nothing to send.
  assign proto_err = (state == BURST) && burst_first && sel_done;
  assign burst_ok  = (state == BURST) && !proto_err;
  assign word_take = burst_ok && phy_data_en;
  assign last_take = word_take && sel_almost;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (|eligible) ? ARB : IDLE;
      ARB:     state_nxt = arb_any ? REQ : IDLE;
      REQ:     state_nxt = phy_gnt ? BURST : REQ;
      BURST:   state_nxt = (proto_err || last_take) ? GAP : BURST;
      GAP:     state_nxt = (gap_cnt >= GAP_LAST) ? IDLE : GAP;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant bookkeeping and sticky error flag.
  always_ff @(negedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      gap_cnt      <= 4'd0;
      burst_first  <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      burst_first <= (state == REQ) && phy_gnt;
      gap_cnt     <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (state == ARB && arb_any) begin
        gnt_idx <= arb_idx;
      end
      if (state == REQ && phy_gnt) begin
        rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
      end
      if (proto_err || (word_take && !sel_valid)) begin
        underrun_err <= 1'b1;
      end
    end
  end

  // Driver-facing outputs; all are forced low outside their owning states.
  always_comb begin
    ch_rd_en = {NUM_CH{word_take}} & gnt_onehot;
    phy_req  = (state == REQ);
    phy_ch   = (state == REQ || state == BURST) ? CH_IDX_W'(gnt_idx) : '0;
    phy_data = burst_ok ? sel_data : '0;
    phy_be   = burst_ok ? sel_be : 4'd0;
    phy_last = burst_ok && sel_almost;
    busy     = (state != IDLE);
  end

`ifdef FT601_ARB_STATS_EN
  // Per-channel packet and word counters, free-running modulo 2^32.
  always_ff @(negedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      stat_pkts  <= '0;
      stat_words <= '0;
    end else if (stat_clr) begin
      stat_pkts  <= '0;
      stat_words <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (word_take && gnt_onehot[i]) begin
          stat_words[32*i +: 32] <= stat_words[32*i +: 32] + 32'd1;
        end
        if (last_take && gnt_onehot[i]) begin
          stat_pkts[32*i +: 32] <= stat_pkts[32*i +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ft601_mcfifo_tx_arbiter.sv
// Self-checking bench: buffer and driver models around the arbiter, a word scoreboard,
// an arbitration vector table and hand-written corner-case sequences.
module tb_ft601_mcfifo_tx_arbiter;

  logic         rd_clk = 1'b1;
  logic         rd_reset_n;
  logic [3:0]   ch_enable, ch_space, ch_xfer_req, ch_xfer_done, ch_xfer_almost_done, ch_rd_valid;
  logic [127:0] ch_rd_data;
  logic [15:0]  ch_rd_be;
  logic [3:0]   ch_rd_en;
  logic         phy_req, phy_gnt, phy_data_en, phy_last, busy, underrun_err;
  logic [1:0]   phy_ch;
  logic [31:0]  phy_data;
  logic [3:0]   phy_be;
`ifdef FT601_ARB_STATS_EN
  logic         stat_clr;
  logic [127:0] stat_pkts, stat_words;
`endif

  always #5 rd_clk = ~rd_clk;

  ft601_mcfifo_tx_arbiter #(.NUM_CH(4), .GAP_CYCLES(2)) dut (
    .rd_clk(rd_clk), .rd_reset_n(rd_reset_n), .ch_enable(ch_enable), .ch_space(ch_space),
    .ch_xfer_req(ch_xfer_req), .ch_xfer_done(ch_xfer_done), .ch_xfer_almost_done(ch_xfer_almost_done),
    .ch_rd_data(ch_rd_data), .ch_rd_be(ch_rd_be), .ch_rd_valid(ch_rd_valid), .ch_rd_en(ch_rd_en),
    .phy_req(phy_req), .phy_ch(phy_ch), .phy_gnt(phy_gnt), .phy_data_en(phy_data_en),
    .phy_data(phy_data), .phy_be(phy_be), .phy_last(phy_last), .busy(busy), .underrun_err(underrun_err)
`ifdef FT601_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_pkts(stat_pkts), .stat_words(stat_words)
`endif
  );

  typedef struct {int ch; logic [31:0] data; logic [3:0] be; logic last;} sb_t;
  typedef struct {logic [3:0] req; logic [3:0] en; logic [3:0] sp; logic exp_req; logic [1:0] exp_ch;} vec_t;

  sb_t        sb[$];
  vec_t       vt[10];
  int         pend[4], wleft[4], pw[4], seq[4], eseq[4], rd_cnt[4];
  logic [3:0] done_force, valid_kill, rd_en_seen;
  logic       auto_gnt, stall_en, in_burst, req_seen, last_seen;
  int         cyc, n_tests, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      ch_xfer_req[i]         = pend[i] > 0;
      ch_xfer_almost_done[i] = (pend[i] > 0) && (wleft[i] == 1);
      ch_xfer_done[i]        = done_force[i];
      ch_rd_valid[i]         = (pend[i] > 0) && !valid_kill[i];
      ch_rd_data[32*i +: 32] = {i[7:0], seq[i][23:0]};
      ch_rd_be[4*i +: 4]     = seq[i][3:0];
    end
  endtask

  task automatic load_pkt(input int ch, input int n);
    pw[ch] = n;
    if (pend[ch] == 0) wleft[ch] = n;
    pend[ch]++;
  endtask

  task automatic expect_pkt(input int ch, input int n);
    sb_t e;
    for (int k = 0; k < n; k++) begin
      e.ch   = ch;
      e.data = {ch[7:0], eseq[ch][23:0]};
      e.be   = eseq[ch][3:0];
      e.last = (k == n - 1);
      sb.push_back(e);
      eseq[ch]++;
    end
  endtask

  // One clock: update buffer/driver models from the last sample, drive, then sample at posedge+1.
  task automatic cycle();
    sb_t e;
    @(posedge rd_clk);
    for (int i = 0; i < 4; i++) begin
      if (rd_en_seen[i]) begin
        seq[i]++;
        rd_cnt[i]++;
        if (wleft[i] <= 1) begin
          pend[i]--;
          wleft[i] = pw[i];
        end else begin
          wleft[i]--;
        end
      end
    end
    if (last_seen) in_burst = 1'b0;
    if (phy_gnt) in_burst = 1'b1;
    phy_gnt = auto_gnt && req_seen && !phy_gnt && !in_burst;
    cyc++;
    phy_data_en = in_burst && !(stall_en && (cyc % 3 == 0));
    drive_inputs();
    #1;
    check("rd_en_onehot", ($countones(ch_rd_en) <= 1) && (phy_data_en || ch_rd_en == 4'd0), 1'b1);
    if (phy_data_en) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("word_ch%0d", e.ch), {ch_rd_en, phy_ch, phy_data, phy_be, phy_last},
              {4'(4'b0001 << e.ch), 2'(e.ch), e.data, e.be, e.last});
      end else begin
        check("no_word", ch_rd_en, 4'd0);
      end
    end
    rd_en_seen = ch_rd_en;
    req_seen   = phy_req;
    last_seen  = phy_data_en && phy_last;
  endtask

  task automatic run_until_done(input string name, input int max);
    int k = 0;
    while (sb.size() > 0 && k < max) begin
      cycle();
      k++;
    end
    check({name, "_timeout"}, k < max, 1'b1);
  endtask

  task automatic do_reset();
    rd_reset_n  = 1'b0;
    phy_gnt     = 1'b0;
    phy_data_en = 1'b0;
    in_burst    = 1'b0;
    req_seen    = 1'b0;
    last_seen   = 1'b0;
    rd_en_seen  = 4'd0;
    done_force  = 4'd0;
    valid_kill  = 4'd0;
    ch_enable   = 4'hF;
    ch_space    = 4'hF;
    auto_gnt    = 1'b1;
    stall_en    = 1'b0;
`ifdef FT601_ARB_STATS_EN
    stat_clr    = 1'b0;
`endif
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0; wleft[i] = 0; pw[i] = 0; rd_cnt[i] = 0; eseq[i] = seq[i];
    end
    drive_inputs();
    repeat (2) @(posedge rd_clk);
    rd_reset_n = 1'b1;
  endtask

  initial begin
    int k;
    logic got;
    logic [1:0] gch;
    n_tests = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < 4; i++) seq[i] = 16 * i;
    rd_reset_n = 1'b1;
    #2;
    do_reset();
    check("reset_state", {ch_rd_en, phy_req, phy_ch, phy_data, phy_be, phy_last, busy, underrun_err}, 64'd0);

    // Arbitration picks from rr_ptr = 0 after reset.
    vt[0] = '{4'b0001, 4'b1111, 4'b1111, 1'b1, 2'd0};
    vt[1] = '{4'b1000, 4'b1111, 4'b1111, 1'b1, 2'd3};
    vt[2] = '{4'b0110, 4'b1111, 4'b1101, 1'b1, 2'd2};
    vt[3] = '{4'b0110, 4'b1101, 4'b1111, 1'b1, 2'd2};
    vt[4] = '{4'b1100, 4'b1111, 4'b1111, 1'b1, 2'd2};
    vt[5] = '{4'b1111, 4'b0000, 4'b1111, 1'b0, 2'd0};
    vt[6] = '{4'b1010, 4'b1111, 4'b0101, 1'b0, 2'd0};
    vt[7] = '{4'b0000, 4'b1111, 4'b1111, 1'b0, 2'd0};
    vt[8] = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 2'd0};
    vt[9] = '{4'b1110, 4'b1011, 4'b1111, 1'b1, 2'd1};
    for (int v = 0; v < 10; v++) begin
      do_reset();
      auto_gnt  = 1'b0;
      ch_enable = vt[v].en;
      ch_space  = vt[v].sp;
      for (int i = 0; i < 4; i++) if (vt[v].req[i]) load_pkt(i, 2);
      got = 1'b0; gch = 2'd0; k = 0;
      while (!got && k < 8) begin
        cycle();
        if (phy_req) begin got = 1'b1; gch = phy_ch; end
        k++;
      end
      check($sformatf("vec%0d", v), {got, gch}, {vt[v].exp_req, vt[v].exp_ch});
    end

    // Single 16-byte packet on ch0, then the 2-cycle gap.
    do_reset();
    load_pkt(0, 4); expect_pkt(0, 4);
    run_until_done("s1_burst", 40);
    cycle(); check("s1_gap1", busy, 1'b1);
    cycle(); check("s1_gap2", busy, 1'b1);
    cycle(); check("s1_idle", busy, 1'b0);
    check("s1_rdcnt", rd_cnt[0], 4);
    check("s1_no_err", underrun_err, 1'b0);

    // All channels requesting: 0,1,2,3,0.
    do_reset();
    load_pkt(0, 2); load_pkt(0, 2); load_pkt(1, 2); load_pkt(2, 2); load_pkt(3, 2);
    expect_pkt(0, 2); expect_pkt(1, 2); expect_pkt(2, 2); expect_pkt(3, 2); expect_pkt(0, 2);
    run_until_done("s2_rr", 200);

    // ch1 without space is skipped, then served once space returns.
    do_reset();
    ch_space = 4'b1101;
    load_pkt(1, 3); load_pkt(2, 3);
    expect_pkt(2, 3);
    run_until_done("s3_skip", 60);
    repeat (6) cycle();
    ch_space = 4'hF;
    expect_pkt(1, 3);
    run_until_done("s3_resume", 60);

    // 4096-byte burst with stalls; ch3 waits for the whole packet.
    do_reset();
    stall_en = 1'b1;
    load_pkt(2, 1024); load_pkt(3, 2);
    expect_pkt(2, 1024); expect_pkt(3, 2);
    run_until_done("s4_long", 2000);
    check("s4_rdcnt", rd_cnt[2], 1024);

    // Underrun is sticky until reset.
    do_reset();
    load_pkt(1, 4); expect_pkt(1, 4);
    k = 0;
    while (!in_burst && k < 20) begin cycle(); k++; end
    check("s5_pre_err", underrun_err, 1'b0);
    valid_kill[1] = 1'b1;
    cycle();
    valid_kill[1] = 1'b0;
    run_until_done("s5_burst", 20);
    check("s5_err_set", underrun_err, 1'b1);
    repeat (5) cycle();
    check("s5_err_hold", underrun_err, 1'b1);
    do_reset();
    check("s5_err_clr", underrun_err, 1'b0);

    // Done already high on burst entry: no pop, error flagged.
    do_reset();
    done_force[1] = 1'b1;
    load_pkt(1, 2);
    repeat (12) cycle();
    check("s6_proto_err", underrun_err, 1'b1);
    check("s6_no_pop", rd_cnt[1], 0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    load_pkt(0, 8); expect_pkt(0, 8);
    k = 0;
    while (!in_burst && k < 20) begin cycle(); k++; end
    cycle();
    @(posedge rd_clk);
    #2;
    rd_reset_n = 1'b0;
    #1;
    check("s7_reset_mid", {ch_rd_en, phy_req, phy_ch, phy_data, phy_be, phy_last, busy}, 64'd0);
    do_reset();

`ifdef FT601_ARB_STATS_EN
    do_reset();
    for (int p = 0; p < 3; p++) begin load_pkt(2, 2); expect_pkt(2, 2); end
    run_until_done("s8_stats", 100);
    cycle();
    check("s8_pkts", stat_pkts[64 +: 32], 32'd3);
    check("s8_words", stat_words[64 +: 32], 32'd6);
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    cycle();
    check("s8_clr", {stat_pkts[64 +: 32], stat_words[64 +: 32]}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
